// File: rtl/faux_sata_hd_phy_gen.sv
// Device-side SATA PHY simulation model: COMINIT/COMWAKE out-of-band exchange, ALIGN lock, SYNC with periodic ALIGN bursts.
// Optional link-loss detection (READY/ALIGN_BURST -> RETRY) is enabled with `define FAUX_HD_LINK_LOSS_EN.

`ifndef PRIM_ALIGN
`define PRIM_ALIGN 32'h7B4A4ABC
`endif
`ifndef PRIM_SYNC
`define PRIM_SYNC 32'hB5B5957C
`endif
`ifndef DIALTONE
`define DIALTONE 32'h4A4A4A4A
`endif

module faux_sata_hd_phy_gen #(
    parameter int COMINIT_COUNT  = 1,
    parameter int COMINIT_GAP    = 4,
    parameter int WAKE_TIMEOUT   = 200,
    parameter int ALIGN_TIMEOUT  = 100,
    parameter int MAX_RETRIES    = 3,
    parameter int ALIGN_INTERVAL = 256,
    parameter int ALIGN_BURST    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] rx_din,
    input  logic [3:0]  rx_is_k,
    input  logic        rx_is_elec_idle,
    input  logic        comm_reset_detect,
    input  logic        comm_wake_detect,
    output logic [31:0] tx_dout,
    output logic [3:0]  tx_is_k,
    output logic        tx_set_elec_idle,
    output logic        tx_comm_reset,
    output logic        tx_comm_wake,
    output logic        rx_byte_is_aligned,
    output logic [3:0]  retry_count,
    output logic        link_fail,
    output logic [3:0]  lax_state,
    output logic        hd_ready,
    output logic        phy_ready
);

    typedef enum logic [3:0] {
        IDLE          = 4'd0,
        WAIT_NO_RESET = 4'd1,
        SEND_INIT     = 4'd2,
        INIT_GAP      = 4'd3,
        WAIT_WAKE     = 4'd4,
        WAIT_NO_WAKE  = 4'd5,
        SEND_WAKE     = 4'd6,
        WAIT_DIALTONE = 4'd7,
        SEND_ALIGN    = 4'd8,
        WAIT_ALIGN    = 4'd9,
        READY         = 4'd10,
        ALIGN_BURST_S = 4'd11,
        RETRY         = 4'd12,
        FAILED        = 4'd13
    } state_t;

    localparam int IW = (ALIGN_INTERVAL > 1) ? $clog2(ALIGN_INTERVAL) : 1;
    localparam int GW = $clog2(COMINIT_GAP + 1);

    state_t          state;
    logic [31:0]     timer;
    logic [3:0]      pulse_cnt;
    logic [GW-1:0]   gap_cnt;
    logic [IW-1:0]   interval_cnt;
    logic [2:0]      burst_cnt;
    logic [3:0]      retry_next;
    logic            align_det;
    logic            dialtone_det;

    // Out-of-band handshake: host detect inputs are level signals; this model waits
    // for each to rise and then fall before answering, and its own tx_comm_* answers
    // are single-cycle pulses. comm_reset_detect outranks every other input.
    assign align_det    = rx_is_k[0] && (rx_din == `PRIM_ALIGN);
    assign dialtone_det = (rx_is_k == 4'b0000) && (rx_din == `DIALTONE);
    assign retry_next   = (retry_count == 4'hF) ? 4'hF : retry_count + 4'd1;
    assign phy_ready    = (state == READY) || (state == ALIGN_BURST_S);
    assign lax_state    = state;

`ifdef FAUX_HD_LINK_LOSS_EN
    logic [4:0] idle_cnt;
    logic       link_lost;
    // 32nd consecutive idle cycle while the link is up
    assign link_lost = phy_ready && rx_is_elec_idle && (idle_cnt == 5'd31);
`else
    logic unused_rx_elec_idle;
    assign unused_rx_elec_idle = rx_is_elec_idle;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= IDLE;
            tx_dout            <= '0;
            tx_is_k            <= '0;
            tx_set_elec_idle   <= 1'b1;
            tx_comm_reset      <= 1'b0;
            tx_comm_wake       <= 1'b0;
            rx_byte_is_aligned <= 1'b0;
            retry_count        <= '0;
            link_fail          <= 1'b0;
            hd_ready           <= 1'b0;
            timer              <= '0;
            pulse_cnt          <= '0;
            gap_cnt            <= '0;
            interval_cnt       <= '0;
            burst_cnt          <= '0;
`ifdef FAUX_HD_LINK_LOSS_EN
            idle_cnt           <= '0;
`endif
        end else begin
            tx_comm_reset <= 1'b0;
            tx_comm_wake  <= 1'b0;
            if (timer != 32'd0) begin
                timer <= timer - 32'd1;
            end
`ifdef FAUX_HD_LINK_LOSS_EN
            if (phy_ready && rx_is_elec_idle) begin
                idle_cnt <= idle_cnt + 5'd1;
            end else begin
                idle_cnt <= '0;
            end
`endif
            if (comm_reset_detect && (state != IDLE) && (state != WAIT_NO_RESET)) begin
                state              <= IDLE;
                tx_dout            <= '0;
                tx_is_k            <= '0;
                tx_set_elec_idle   <= 1'b1;
                rx_byte_is_aligned <= 1'b0;
                hd_ready           <= 1'b0;
                pulse_cnt          <= '0;
                timer              <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        tx_dout            <= '0;
                        tx_is_k            <= '0;
                        tx_set_elec_idle   <= 1'b1;
                        rx_byte_is_aligned <= 1'b0;
                        hd_ready           <= 1'b0;
                        pulse_cnt          <= '0;
                        if (comm_reset_detect) begin
                            retry_count <= '0;
                            link_fail   <= 1'b0;
                            state       <= WAIT_NO_RESET;
                        end
                    end
                    WAIT_NO_RESET: begin
                        if (!comm_reset_detect) begin
                            state <= SEND_INIT;
                        end
                    end
                    SEND_INIT: begin
                        tx_comm_reset <= 1'b1;
                        pulse_cnt     <= pulse_cnt + 4'd1;
                        gap_cnt       <= '0;
                        if (pulse_cnt + 4'd1 == 4'(COMINIT_COUNT)) begin
                            timer <= 32'(WAKE_TIMEOUT);
                            state <= WAIT_WAKE;
                        end else begin
                            state <= INIT_GAP;
                        end
                    end
                    INIT_GAP: begin
                        if (gap_cnt == GW'(COMINIT_GAP - 1)) begin
                            state <= SEND_INIT;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                    WAIT_WAKE: begin
                        if (comm_wake_detect) begin
                            state <= WAIT_NO_WAKE;
                        end else if (timer == 32'd0) begin
                            state <= RETRY;
                        end
                    end
                    WAIT_NO_WAKE: begin
                        if (!comm_wake_detect) begin
                            state <= SEND_WAKE;
                        end
                    end
                    SEND_WAKE: begin
                        tx_comm_wake <= 1'b1;
                        state        <= WAIT_DIALTONE;
                    end
                    WAIT_DIALTONE: begin
                        if (dialtone_det) begin
                            state <= SEND_ALIGN;
                        end
                    end
                    SEND_ALIGN: begin
                        tx_set_elec_idle   <= 1'b0;
                        tx_dout            <= `PRIM_ALIGN;
                        tx_is_k            <= 4'b0001;
                        timer              <= 32'(ALIGN_TIMEOUT);
                        rx_byte_is_aligned <= 1'b1;
                        state              <= WAIT_ALIGN;
                    end
                    WAIT_ALIGN: begin
                        tx_set_elec_idle <= 1'b0;
                        tx_dout          <= `PRIM_ALIGN;
                        tx_is_k          <= 4'b0001;
                        // a host ALIGN arriving on the timeout cycle still locks
                        if (align_det) begin
                            interval_cnt <= '0;
                            state        <= READY;
                        end else if (timer == 32'd0) begin
                            state <= RETRY;
                        end
                    end
                    READY: begin
                        hd_ready         <= 1'b1;
                        tx_set_elec_idle <= 1'b0;
                        tx_dout          <= `PRIM_SYNC;
                        tx_is_k          <= 4'b0001;
                        interval_cnt     <= interval_cnt + 1'b1;
                        // the interval is the full SYNC+ALIGN period, so the burst
                        // occupies its last ALIGN_BURST counts
                        if (interval_cnt == IW'(ALIGN_INTERVAL - ALIGN_BURST - 1)) begin
                            burst_cnt <= '0;
                            state     <= ALIGN_BURST_S;
                        end
                    end
                    ALIGN_BURST_S: begin
                        hd_ready         <= 1'b1;
                        tx_set_elec_idle <= 1'b0;
                        tx_dout          <= `PRIM_ALIGN;
                        tx_is_k          <= 4'b0001;
                        burst_cnt        <= burst_cnt + 3'd1;
                        if (burst_cnt == 3'(ALIGN_BURST - 1)) begin
                            interval_cnt <= '0;
                            state        <= READY;
                        end else begin
                            interval_cnt <= interval_cnt + 1'b1;
                        end
                    end
                    RETRY: begin
                        retry_count        <= retry_next;
                        tx_set_elec_idle   <= 1'b1;
                        tx_dout            <= '0;
                        tx_is_k            <= '0;
                        rx_byte_is_aligned <= 1'b0;
                        hd_ready           <= 1'b0;
                        if (retry_next == 4'(MAX_RETRIES)) begin
                            link_fail <= 1'b1;
                            state     <= FAILED;
                        end else begin
                            pulse_cnt <= '0;
                            state     <= SEND_INIT;
                        end
                    end
                    FAILED: begin
                        link_fail          <= 1'b1;
                        tx_set_elec_idle   <= 1'b1;
                        tx_dout            <= '0;
                        tx_is_k            <= '0;
                        rx_byte_is_aligned <= 1'b0;
                        hd_ready           <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
`ifdef FAUX_HD_LINK_LOSS_EN
                if (link_lost) begin
                    state <= RETRY;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_faux_sata_hd_phy_gen.sv
// Self-checking bench for faux_sata_hd_phy_gen: handshake vector table plus hand-written burst, abort, reset, timeout and retry sequences.
// Link-loss checks are compiled in when FAUX_HD_LINK_LOSS_EN is defined.

module tb_faux_sata_hd_phy_gen;

    localparam logic [31:0] ALIGN_W = 32'h7B4A4ABC;
    localparam logic [31:0] SYNC_W  = 32'hB5B5957C;
    localparam logic [31:0] DIAL_W  = 32'h4A4A4A4A;

    localparam logic [3:0] S_IDLE = 4'd0, S_WNR = 4'd1, S_INIT = 4'd2, S_GAP = 4'd3;
    localparam logic [3:0] S_WW = 4'd4, S_WNW = 4'd5, S_SW = 4'd6, S_WD = 4'd7;
    localparam logic [3:0] S_SA = 4'd8, S_WA = 4'd9, S_RDY = 4'd10, S_BUR = 4'd11;
    localparam logic [3:0] S_RET = 4'd12, S_FAIL = 4'd13;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] rx_din = '0;
    logic [3:0]  rx_is_k = '0;
    logic        rx_is_elec_idle = 1'b0;
    logic        comm_reset_detect = 1'b0;
    logic        comm_wake_detect = 1'b0;
    logic [31:0] tx_dout;
    logic [3:0]  tx_is_k;
    logic        tx_set_elec_idle, tx_comm_reset, tx_comm_wake, rx_byte_is_aligned;
    logic [3:0]  retry_count, lax_state;
    logic        link_fail, hd_ready, phy_ready;

    faux_sata_hd_phy_gen #(
        .COMINIT_COUNT(3), .COMINIT_GAP(4), .WAKE_TIMEOUT(20), .ALIGN_TIMEOUT(30),
        .MAX_RETRIES(3), .ALIGN_INTERVAL(16), .ALIGN_BURST(3)
    ) dut (
        .clk(clk), .rst(rst), .rx_din(rx_din), .rx_is_k(rx_is_k),
        .rx_is_elec_idle(rx_is_elec_idle), .comm_reset_detect(comm_reset_detect),
        .comm_wake_detect(comm_wake_detect), .tx_dout(tx_dout), .tx_is_k(tx_is_k),
        .tx_set_elec_idle(tx_set_elec_idle), .tx_comm_reset(tx_comm_reset),
        .tx_comm_wake(tx_comm_wake), .rx_byte_is_aligned(rx_byte_is_aligned),
        .retry_count(retry_count), .link_fail(link_fail), .lax_state(lax_state),
        .hd_ready(hd_ready), .phy_ready(phy_ready)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int cr_q[$];
    int cw_q[$];
    logic [31:0] exp_q[$];

    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (tx_comm_reset) cr_q.push_back(cyc);
        if (tx_comm_wake)  cw_q.push_back(cyc);
    end

    typedef struct {
        logic        cr;
        logic        cw;
        logic [31:0] din;
        logic [3:0]  k;
        int          n;
        logic [3:0]  st;
        logic        eidle;
        logic        hdr;
        logic [31:0] dout;
        logic [3:0]  dk;
        logic        algn;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(logic cr, logic cw, logic [31:0] din, logic [3:0] k, int n,
                                logic [3:0] st, logic eidle, logic hdr, logic [31:0] dout,
                                logic [3:0] dk, logic algn);
        vec_t v;
        v.cr = cr; v.cw = cw; v.din = din; v.k = k; v.n = n; v.st = st;
        v.eidle = eidle; v.hdr = hdr; v.dout = dout; v.dk = dk; v.algn = algn;
        return v;
    endfunction

    // driver tasks
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget, input string name);
        int i;
        i = 0;
        while (lax_state !== s && i < budget) begin
            step(1);
            i++;
        end
        check(name, {28'd0, lax_state}, {28'd0, s});
    endtask

    task automatic run_table(input int upto);
        for (int i = 0; i < upto; i++) begin
            comm_reset_detect = vecs[i].cr;
            comm_wake_detect  = vecs[i].cw;
            rx_din            = vecs[i].din;
            rx_is_k           = vecs[i].k;
            step(vecs[i].n);
            check($sformatf("vec%0d_state", i), {28'd0, lax_state}, {28'd0, vecs[i].st});
            check($sformatf("vec%0d_flags", i), {29'd0, tx_set_elec_idle, hd_ready, rx_byte_is_aligned},
                  {29'd0, vecs[i].eidle, vecs[i].hdr, vecs[i].algn});
            check($sformatf("vec%0d_dout", i), tx_dout, vecs[i].dout);
            check($sformatf("vec%0d_k", i), {28'd0, tx_is_k}, {28'd0, vecs[i].dk});
            check($sformatf("vec%0d_phy_ready", i), {31'd0, phy_ready},
                  {31'd0, (vecs[i].st == S_RDY) || (vecs[i].st == S_BUR)});
            check($sformatf("vec%0d_retry_fail", i), {27'd0, retry_count, link_fail}, 32'd0);
        end
    endtask

    initial begin
        int n;
        //             cr    cw    din     k     n   state  eidle hdr  dout     dk    algn
        vecs[0]  = mk(1'b1, 1'b0, 32'd0,  4'h0, 10, S_WNR,  1'b1, 1'b0, 32'd0,   4'h0, 1'b0);
        vecs[1]  = mk(1'b0, 1'b0, 32'd0,  4'h0, 1,  S_INIT, 1'b1, 1'b0, 32'd0,   4'h0, 1'b0);
        vecs[2]  = mk(1'b0, 1'b0, 32'd0,  4'h0, 1,  S_GAP,  1'b1, 1'b0, 32'd0,   4'h0, 1'b0);
        vecs[3]  = mk(1'b0, 1'b0, 32'd0,  4'h0, 4,  S_INIT, 1'b1, 1'b0, 32'd0,   4'h0, 1'b0);
        vecs[4]  = mk(1'b0, 1'b0, 32'd0,  4'h0, 5,  S_INIT, 1'b1, 1'b0, 32'd0,   4'h0, 1'b0);
        vecs[5]  = mk(1'b0, 1'b0, 32'd0,  4'h0, 1,  S_WW,   1'b1, 1'b0, 32'd0,   4'h0, 1'b0);
        vecs[6]  = mk(1'b0, 1'b1, 32'd0,  4'h0, 10, S_WNW,  1'b1, 1'b0, 32'd0,   4'h0, 1'b0);
        vecs[7]  = mk(1'b0, 1'b0, 32'd0,  4'h0, 1,  S_SW,   1'b1, 1'b0, 32'd0,   4'h0, 1'b0);
        vecs[8]  = mk(1'b0, 1'b0, 32'd0,  4'h0, 1,  S_WD,   1'b1, 1'b0, 32'd0,   4'h0, 1'b0);
        vecs[9]  = mk(1'b0, 1'b0, DIAL_W, 4'h0, 1,  S_SA,   1'b1, 1'b0, 32'd0,   4'h0, 1'b0);
        vecs[10] = mk(1'b0, 1'b0, 32'd0,  4'h0, 1,  S_WA,   1'b0, 1'b0, ALIGN_W, 4'h1, 1'b1);
        vecs[11] = mk(1'b0, 1'b0, ALIGN_W,4'h1, 1,  S_RDY,  1'b0, 1'b0, ALIGN_W, 4'h1, 1'b1);
        vecs[12] = mk(1'b0, 1'b0, SYNC_W, 4'h1, 1,  S_RDY,  1'b0, 1'b1, SYNC_W,  4'h1, 1'b1);

        // reset state
        step(3);
        check("reset_state", {28'd0, lax_state}, {28'd0, S_IDLE});
        check("reset_dout_k", {tx_dout[27:0], tx_is_k}, 32'd0);
        check("reset_flags", {25'd0, tx_set_elec_idle, tx_comm_reset, tx_comm_wake,
              rx_byte_is_aligned, link_fail, hd_ready, phy_ready}, 32'h40);
        check("reset_retry", {28'd0, retry_count}, 32'd0);
        #2 rst = 1'b1;
        step(1);

        // nominal handshake with three COMINIT pulses spaced five cycles apart
        cr_q.delete();
        cw_q.delete();
        run_table(13);
        check("cominit_pulses", cr_q.size(), 3);
        if (cr_q.size() == 3) begin
            check("cominit_gap1", cr_q[1] - cr_q[0], 5);
            check("cominit_gap2", cr_q[2] - cr_q[1], 5);
        end
        check("comwake_pulses", cw_q.size(), 1);

        // periodic burst: 3 ALIGN then 13 SYNC, repeating
        n = 0;
        while (tx_dout !== ALIGN_W && n < 40) begin
            step(1);
            n++;
        end
        check("burst_start", tx_dout, ALIGN_W);
        for (int i = 0; i < 32; i++) exp_q.push_back(((i % 16) < 3) ? ALIGN_W : SYNC_W);
        for (int i = 0; i < 32; i++) begin
            check($sformatf("burst_word%0d", i), tx_dout, exp_q.pop_front());
            check($sformatf("burst_k%0d", i), {27'd0, hd_ready, tx_is_k}, 32'h11);
            step(1);
        end

        // abort from READY
        wait_state(S_RDY, 20, "abort_pre_ready");
        comm_reset_detect = 1'b1;
        step(1);
        check("abort_state", {28'd0, lax_state}, {28'd0, S_IDLE});
        check("abort_hd_ready", {30'd0, hd_ready, phy_ready}, 32'd0);

        // restart, then async reset in the middle of a burst
        run_table(13);
        wait_state(S_BUR, 40, "pre_reset_burst");
        #2 rst = 1'b0;
        #1;
        check("async_state", {28'd0, lax_state}, {28'd0, S_IDLE});
        check("async_dout", tx_dout, 32'd0);
        check("async_flags", {26'd0, tx_is_k, tx_set_elec_idle, hd_ready},
              {26'd0, 4'h0, 1'b1, 1'b0});
        check("async_aligned", {30'd0, rx_byte_is_aligned, phy_ready}, 32'd0);
        #1 rst = 1'b1;
        step(1);
        check("post_reset_idle", {28'd0, lax_state}, {28'd0, S_IDLE});

        // host ALIGN on the same cycle the align timer reaches zero
        run_table(10);
        rx_din = 32'd0;
        rx_is_k = 4'h0;
        step(1);
        check("wa_enter", {28'd0, lax_state}, {28'd0, S_WA});
        step(30);
        check("wa_at_timeout", {28'd0, lax_state}, {28'd0, S_WA});
        rx_din = ALIGN_W;
        rx_is_k = 4'h1;
        step(1);
        check("wa_align_wins", {28'd0, lax_state}, {28'd0, S_RDY});
        rx_din = SYNC_W;

`ifdef FAUX_HD_LINK_LOSS_EN
        rx_is_elec_idle = 1'b1;
        step(31);
        check("idle31_stays", {31'd0, phy_ready}, 32'd1);
        rx_is_elec_idle = 1'b0;
        step(1);
        rx_is_elec_idle = 1'b1;
        step(32);
        check("idle32_retry", {28'd0, lax_state}, {28'd0, S_RET});
        rx_is_elec_idle = 1'b0;
        step(1);
        check("idle32_retry_count", {28'd0, retry_count}, 32'd1);
        check("idle32_reinit", {28'd0, lax_state}, {28'd0, S_INIT});
`endif

        // withhold COMWAKE: three timeouts end in FAILED
        comm_reset_detect = 1'b1;
        rx_din = 32'd0;
        rx_is_k = 4'h0;
        step(3);
        check("retry_pre", {27'd0, retry_count, link_fail}, 32'd0);
        comm_reset_detect = 1'b0;
        for (int r = 1; r <= 3; r++) begin
            wait_state(S_WW, 40, $sformatf("retry%0d_wait_wake", r));
            n = 0;
            while (lax_state === S_WW && n < 100) begin
                n++;
                step(1);
            end
            check($sformatf("retry%0d_timeout_len", r), n, 21);
            check($sformatf("retry%0d_in_retry", r), {28'd0, lax_state}, {28'd0, S_RET});
            step(1);
            check($sformatf("retry%0d_count", r), {28'd0, retry_count}, r);
            check($sformatf("retry%0d_next", r), {28'd0, lax_state}, {28'd0, (r < 3) ? S_INIT : S_FAIL});
            check($sformatf("retry%0d_link_fail", r), {31'd0, link_fail}, {31'd0, r == 3});
        end
        step(5);
        check("failed_holds", {27'd0, lax_state, link_fail}, {27'd0, S_FAIL, 1'b1});
        check("failed_eidle", {31'd0, tx_set_elec_idle}, 32'd1);
        comm_reset_detect = 1'b1;
        step(1);
        check("failed_abort", {28'd0, lax_state}, {28'd0, S_IDLE});
        step(1);
        check("restart_clear", {27'd0, retry_count, link_fail}, 32'd0);
        comm_reset_detect = 1'b0;
        step(1);
        check("restart_init", {28'd0, lax_state}, {28'd0, S_INIT});
        step(1);
        check("restart_pulse", {31'd0, tx_comm_reset}, 32'd1);
        check("restart_gap", {28'd0, lax_state}, {28'd0, S_GAP});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
